ddr_rw_scheduler: RTL and testbench

Read/write turnaround scheduler between the multichannel read arbiter and multichannel write arbiter, and the single DDR3 controller port. It accepts one pending arbitrated read burst and one pending arbitrated write burst, and runs exactly one burst at a time. Same-direction bursts are grouped to cut bus turnaround, with a bounded run length so neither direction starves. A per-burst watchdog recovers from a missing done.

---
 rtl/ddr_rw_scheduler.sv | 143 ++++++++++++++
 tb/tb_ddr_rw_scheduler.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_rw_scheduler.sv
// Read/write turnaround scheduler: one DDR burst at a time, same-direction runs bounded by MAX_SAME.
// Grant/start/addr/len registered one cycle after the IDLE decision; requests wait while busy.
module ddr_rw_scheduler #(
  parameter int ADDR_W   = 30,
  parameter int LEN_W    = 8,
  parameter int MAX_SAME = 4,
  parameter int TIMEOUT  = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [LEN_W-1:0]  rd_len,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [LEN_W-1:0]  wr_len,
  output logic              rd_grant,
  output logic              wr_grant,
  output logic              axi_rd_start,
  output logic [ADDR_W-1:0] axi_rd_addr,
  output logic [LEN_W-1:0]  axi_rd_len,
  output logic              axi_wr_start,
  output logic [ADDR_W-1:0] axi_wr_addr,
  output logic [LEN_W-1:0]  axi_wr_len,
  input  logic              rd_done,
  input  logic              wr_done,
  output logic              busy,
  output logic              timeout_err,
  input  logic              err_clr
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);
  localparam logic [3:0]      SAME_MAX = 4'(MAX_SAME);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;

  state_t            r_state;
  logic              r_last_dir;
  logic [3:0]        r_same_cnt;
  logic [WD_W-1:0]   r_wdog;
  logic              r_rd_go;
  logic              r_wr_go;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [LEN_W-1:0]  r_rd_len;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [LEN_W-1:0]  r_wr_len;
  logic              r_err;

  logic w_go;
  logic w_pick_wr;
  logic w_same;

  // With both pending, stay on the current direction until the run limit is hit.
  always_comb begin
    w_pick_wr = wr_req;
    if (rd_req && wr_req) begin
      w_pick_wr = (r_same_cnt >= SAME_MAX) ? ~r_last_dir : r_last_dir;
    end
  end

  assign w_go   = rd_req | wr_req;
  assign w_same = (w_pick_wr == r_last_dir);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_last_dir <= 1'b0;
      r_same_cnt <= 4'd0;
      r_wdog     <= '0;
      r_rd_go    <= 1'b0;
      r_wr_go    <= 1'b0;
      r_rd_addr  <= '0;
      r_rd_len   <= '0;
      r_wr_addr  <= '0;
      r_wr_len   <= '0;
      r_err      <= 1'b0;
    end else begin
      r_rd_go <= 1'b0;
      r_wr_go <= 1'b0;
      if (err_clr) r_err <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_go) begin
            if (w_pick_wr) begin
              r_state   <= S_WR;
              r_wr_go   <= 1'b1;
              r_wr_addr <= wr_addr;
              r_wr_len  <= wr_len;
            end else begin
              r_state   <= S_RD;
              r_rd_go   <= 1'b1;
              r_rd_addr <= rd_addr;
              r_rd_len  <= rd_len;
            end
            if (w_same) begin
              if (r_same_cnt < SAME_MAX) r_same_cnt <= r_same_cnt + 4'd1;
            end else begin
              r_same_cnt <= 4'd1;
              r_last_dir <= w_pick_wr;
            end
            r_wdog <= '0;
          end
        end
        S_RD: begin
          if (rd_done) begin
            r_state <= S_IDLE;
          end else if (r_wdog == WD_LAST) begin
            r_err   <= 1'b1;  // overrides a same-cycle err_clr
            r_state <= S_IDLE;
          end else begin
            r_wdog <= r_wdog + WD_ONE;
          end
        end
        S_WR: begin
          if (wr_done) begin
            r_state <= S_IDLE;
          end else if (r_wdog == WD_LAST) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_wdog <= r_wdog + WD_ONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rd_grant     = r_rd_go;
  assign axi_rd_start = r_rd_go;
  assign wr_grant     = r_wr_go;
  assign axi_wr_start = r_wr_go;
  assign axi_rd_addr  = r_rd_addr;
  assign axi_rd_len   = r_rd_len;
  assign axi_wr_addr  = r_wr_addr;
  assign axi_wr_len   = r_wr_len;
  assign busy         = (r_state != S_IDLE);
  assign timeout_err  = r_err;

endmodule

// File: tb/tb_ddr_rw_scheduler.sv
// Randomized bench for ddr_rw_scheduler against a grant-history reference model.
module tb_ddr_rw_scheduler;
  localparam int ADDR_W = 30, LEN_W = 8, MAX_SAME = 4, TIMEOUT = 1023;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              rd_req = 0, wr_req = 0, rd_done = 0, wr_done = 0, err_clr = 0;
  logic [ADDR_W-1:0] rd_addr = '0, wr_addr = '0;
  logic [LEN_W-1:0]  rd_len = '0, wr_len = '0;
  logic              rd_grant, wr_grant, axi_rd_start, axi_wr_start, busy, timeout_err;
  logic [ADDR_W-1:0] axi_rd_addr, axi_wr_addr;
  logic [LEN_W-1:0]  axi_rd_len, axi_wr_len;

  ddr_rw_scheduler #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .MAX_SAME(MAX_SAME), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len),
    .rd_grant(rd_grant), .wr_grant(wr_grant),
    .axi_rd_start(axi_rd_start), .axi_rd_addr(axi_rd_addr), .axi_rd_len(axi_rd_len),
    .axi_wr_start(axi_wr_start), .axi_wr_addr(axi_wr_addr), .axi_wr_len(axi_wr_len),
    .rd_done(rd_done), .wr_done(wr_done),
    .busy(busy), .timeout_err(timeout_err), .err_clr(err_clr)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference model: direction in flight (-1 idle), age of burst in cycles, list of past grants.
  int                m_dir = -1;
  int                m_age = 0;
  int                hist[$];
  bit                m_err = 0;
  bit                e_rg = 0, e_wg = 0;
  logic [ADDR_W-1:0] e_ra = '0, e_wa = '0;
  logic [LEN_W-1:0]  e_rl = '0, e_wl = '0;

  int dn_cnt = -1;
  int dly_mode = 0;   // 0: done 8 cycles after start, 1: random 0..12, 2: never
  int p_rd = 0, p_wr = 0, stray_pct = 0, clr_pct = 0;
  bit rec = 0;
  int obs_q[$];
  int t_start = -1, t_err = -1;

  function automatic int pick_dir();
    int last, run;
    last = (hist.size() == 0) ? 0 : hist[hist.size()-1];
    run = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] != last) break;
      run++;
    end
    return (run >= MAX_SAME) ? 1 - last : last;
  endfunction

  task automatic model_reset();
    m_dir = -1; m_age = 0; hist.delete(); m_err = 0;
    e_rg = 0; e_wg = 0; e_ra = '0; e_wa = '0; e_rl = '0; e_wl = '0;
    dn_cnt = -1;
  endtask

  task automatic model_step();
    int d;
    bit set;
    set = 0;
    e_rg = 0; e_wg = 0;
    if (m_dir < 0) begin
      if (rd_req || wr_req) begin
        d = (rd_req && wr_req) ? pick_dir() : (wr_req ? 1 : 0);
        hist.push_back(d);
        m_dir = d;
        m_age = 1;
        if (d == 0) begin e_rg = 1; e_ra = rd_addr; e_rl = rd_len; end
        else        begin e_wg = 1; e_wa = wr_addr; e_wl = wr_len; end
        dn_cnt = (dly_mode == 0) ? 8 : (dly_mode == 1) ? int'($urandom_range(0, 12)) : -1;
      end
    end else if ((m_dir == 0 && rd_done) || (m_dir == 1 && wr_done)) begin
      m_dir = -1;
    end else if (m_age == TIMEOUT) begin
      set = 1;
      m_dir = -1;
    end else begin
      m_age++;
    end
    if (set) m_err = 1;
    else if (err_clr) m_err = 0;
  endtask

  task automatic compare_all();
    chk("rd_grant",     64'(rd_grant),     64'(e_rg));
    chk("wr_grant",     64'(wr_grant),     64'(e_wg));
    chk("axi_rd_start", 64'(axi_rd_start), 64'(e_rg));
    chk("axi_wr_start", 64'(axi_wr_start), 64'(e_wg));
    chk("axi_rd_addr",  64'(axi_rd_addr),  64'(e_ra));
    chk("axi_rd_len",   64'(axi_rd_len),   64'(e_rl));
    chk("axi_wr_addr",  64'(axi_wr_addr),  64'(e_wa));
    chk("axi_wr_len",   64'(axi_wr_len),   64'(e_wl));
    chk("busy",         64'(busy),         64'(m_dir >= 0));
    chk("timeout_err",  64'(timeout_err),  64'(m_err));
  endtask

  // Called at the falling edge: drive requests, done responses, strays and clears.
  task automatic drive();
    rd_done = 0; wr_done = 0;
    if (m_dir >= 0 && dn_cnt >= 0) begin
      if (dn_cnt == 0) begin
        if (m_dir == 0) rd_done = 1; else wr_done = 1;
        dn_cnt = -1;
      end else begin
        dn_cnt--;
      end
    end
    if (int'($urandom_range(0, 99)) < stray_pct) begin
      if (m_dir == 0)      wr_done = 1;
      else if (m_dir == 1) rd_done = 1;
      else begin rd_done = 1'($urandom); wr_done = ~rd_done; end
    end
    if (e_rg) rd_req = 0;
    if (e_wg) wr_req = 0;
    if (!rd_req && int'($urandom_range(0, 99)) < p_rd) begin
      rd_req = 1; rd_addr = ADDR_W'($urandom); rd_len = LEN_W'($urandom);
    end
    if (!wr_req && int'($urandom_range(0, 99)) < p_wr) begin
      wr_req = 1; wr_addr = ADDR_W'($urandom); wr_len = LEN_W'($urandom);
    end
    err_clr = (int'($urandom_range(0, 99)) < clr_pct);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    compare_all();
    if (rec && rd_grant) obs_q.push_back(0);
    if (rec && wr_grant) obs_q.push_back(1);
    if (axi_rd_start === 1'b1 && t_start < 0) t_start = cyc;
    if (timeout_err === 1'b1 && t_err < 0) t_err = cyc;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      drive();
      cycle();
    end
  endtask

  task automatic apply_reset();
    rst_n = 0;
    rd_req = 0; wr_req = 0; rd_done = 0; wr_done = 0; err_clr = 0;
    rd_addr = '0; wr_addr = '0; rd_len = '0; wr_len = '0;
    model_reset();
    @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    int n_rd, n_wr;
    @(negedge clk);
    apply_reset();

    // First request after reset
    p_rd = 0; p_wr = 0; stray_pct = 0; clr_pct = 0; dly_mode = 0;
    rd_req = 1; rd_addr = 30'h10; rd_len = 8'd7;
    cycle();
    chk("first_rd_grant", 64'(rd_grant), 64'd1);
    chk("first_rd_addr",  64'(axi_rd_addr), 64'h10);
    chk("first_rd_len",   64'(axi_rd_len), 64'd7);
    run(1);
    chk("first_pulse_width", 64'(axi_rd_start), 64'd0);
    run(15);

    // Both directions permanently pending
    apply_reset();
    p_rd = 100; p_wr = 100; dly_mode = 0; rec = 1; obs_q.delete();
    run(200);
    rec = 0;
    for (int i = 0; i < 16; i++)
      chk("run_order", 64'((i < obs_q.size()) ? obs_q[i] : 9), 64'((i / 4) % 2));

    // Write only
    apply_reset();
    p_rd = 0; p_wr = 100; rec = 1; obs_q.delete();
    run(70);
    rec = 0;
    n_rd = 0; n_wr = 0;
    foreach (obs_q[i]) if (obs_q[i] == 0) n_rd++; else n_wr++;
    chk("wr_only_count", 64'(n_wr >= 6), 64'd1);
    chk("wr_only_no_rd", 64'(n_rd), 64'd0);

    // Watchdog
    apply_reset();
    p_rd = 0; p_wr = 0; dly_mode = 2; t_start = -1; t_err = -1;
    rd_req = 1; rd_addr = ADDR_W'($urandom); rd_len = LEN_W'($urandom);
    run(1030);
    chk("wdog_latency", 64'(t_err - t_start), 64'(TIMEOUT));
    chk("wdog_err", 64'(timeout_err), 64'd1);
    dly_mode = 0;
    wr_req = 1; wr_addr = ADDR_W'($urandom); wr_len = LEN_W'($urandom);
    cycle();
    chk("wdog_then_wr", 64'(wr_grant), 64'd1);
    run(12);
    drive();
    err_clr = 1;
    cycle();
    chk("err_clr", 64'(timeout_err), 64'd0);
    run(3);

    // Random traffic with stray dones and occasional clears
    apply_reset();
    p_rd = 40; p_wr = 40; dly_mode = 1; stray_pct = 15; clr_pct = 3;
    run(1500);

    // Reset during a write burst
    apply_reset();
    p_rd = 0; p_wr = 0; dly_mode = 2; stray_pct = 0; clr_pct = 0;
    wr_req = 1; wr_addr = ADDR_W'($urandom); wr_len = LEN_W'($urandom);
    run(4);
    rst_n = 0;
    #1;
    chk("async_rst_busy", 64'(busy), 64'd0);
    rd_req = 0; wr_req = 0; rd_done = 0; wr_done = 0; err_clr = 0;
    rd_addr = '0; wr_addr = '0; rd_len = '0; wr_len = '0;
    model_reset();
    @(negedge clk);
    rst_n = 1;
    dly_mode = 0;
    rd_req = 1; rd_addr = ADDR_W'($urandom); rd_len = LEN_W'($urandom);
    wr_req = 1; wr_addr = ADDR_W'($urandom); wr_len = LEN_W'($urandom);
    cycle();
    chk("post_rst_rd_first", 64'(rd_grant), 64'd1);
    run(30);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
